// File: rtl/msk_linmap_seq.sv
// msk_linmap_seq: time-multiplexed sequencer for a masked byte-wise linear map.
//
// Takes a full shared state in shbit encoding, sends one shared byte per cycle
// to one external pipelined byte mapper, and writes each result back in place.
// When every byte has been mapped, it presents the mapped state. Shares are
// never combined: the block only moves whole 8*D-bit byte slices.
//
// Parameters:
//   D     number of shares
//   COUNT number of bytes in the state
//   LAT   fixed mapper latency in cycles (0..4)
//
// Ports:
//   ClkxCI, RstxBI                 clock, async active-low reset
//   InValidxSI/InReadyxSO          input state handshake
//   InDataxDI, InSelxSI            shared state (byte j at [8*D*j +: 8*D]), matrix select
//   OutValidxSO/OutReadyxSI        mapped state handshake
//   OutDataxDO                     mapped state, zero outside DONE
//   MapDataxDO/MapSelxSO/MapValidxSO  issue to the mapper, data zero when not issuing
//   MapDataxDI                     mapper result, LAT cycles after issue
//   BusyxSO                        high in ISSUE, DRAIN or DONE
//   ByteIdxxSO                     byte issued this cycle, 0 when not issuing
//
// Build option: define MSKLIN_SEQ_CLEAR_EN to wipe the state buffer and select
// register on the output handshake, so no share residue stays in IDLE.

module msk_linmap_seq #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 16,
  parameter int unsigned LAT   = 1,
  localparam int unsigned IdxW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                    ClkxCI,
  input  logic                    RstxBI,
  input  logic                    InValidxSI,
  output logic                    InReadyxSO,
  input  logic [8*COUNT*D-1:0]    InDataxDI,
  input  logic                    InSelxSI,
  output logic                    OutValidxSO,
  input  logic                    OutReadyxSI,
  output logic [8*COUNT*D-1:0]    OutDataxDO,
  output logic [8*D-1:0]          MapDataxDO,
  output logic                    MapSelxSO,
  output logic                    MapValidxSO,
  input  logic [8*D-1:0]          MapDataxDI,
  output logic                    BusyxSO,
  output logic [IdxW-1:0]         ByteIdxxSO
);

  localparam int unsigned ByteW = 8 * D;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(COUNT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e          fsm_q, fsm_d;
  logic [ByteW-1:0] mem_q [COUNT];
  logic            sel_q;
  logic [IdxW-1:0] cnt_q;

  logic            accept;
  logic            issue_vld;
  logic            last_issue;
  logic            out_hs;
  logic            tail_vld;
  logic [IdxW-1:0] tail_idx;

  assign accept     = (fsm_q == StIdle) & InValidxSI;
  assign issue_vld  = (fsm_q == StIssue);
  assign last_issue = issue_vld & (cnt_q == LastIdx);
  assign out_hs     = (fsm_q == StDone) & OutReadyxSI;

  // Capture pipe: tracks which byte the mapper result at its tail belongs to.
  // Reset clears it, so returns for a discarded job are never written back.
  if (LAT == 0) begin : g_no_pipe
    assign tail_vld = issue_vld;
    assign tail_idx = cnt_q;
  end else begin : g_pipe
    logic [LAT-1:0]  vld_q;
    logic [IdxW-1:0] idx_q [LAT];

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < LAT; i++) idx_q[i] <= '0;
      end else begin
        vld_q[0] <= issue_vld;
        idx_q[0] <= cnt_q;
        for (int unsigned i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign tail_vld = vld_q[LAT-1];
    assign tail_idx = idx_q[LAT-1];
  end

  // State register
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) fsm_q <= StIdle;
    else         fsm_q <= fsm_d;
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (accept) fsm_d = StIssue;
      StIssue: if (last_issue) fsm_d = (LAT > 0) ? StDrain : StDone;
      // Issues are in byte order, so the last capture carries the last index.
      StDrain: if (tail_vld && (tail_idx == LastIdx)) fsm_d = StDone;
      StDone:  if (OutReadyxSI) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // Buffer, select register and issue counter
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      for (int unsigned j = 0; j < COUNT; j++) mem_q[j] <= '0;
      sel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        for (int unsigned j = 0; j < COUNT; j++) mem_q[j] <= InDataxDI[ByteW*j +: ByteW];
        sel_q <= InSelxSI;
      end else if (tail_vld) begin
        mem_q[tail_idx] <= MapDataxDI;
      end
`ifdef MSKLIN_SEQ_CLEAR_EN
      else if (out_hs) begin
        for (int unsigned j = 0; j < COUNT; j++) mem_q[j] <= '0;
        sel_q <= 1'b0;
      end
`endif
      if (accept) begin
        cnt_q <= '0;
      end else if (issue_vld) begin
        // Explicit terminal compare keeps non-power-of-2 COUNT correct.
        cnt_q <= last_issue ? '0 : cnt_q + IdxW'(1);
      end
    end
  end

  // Outputs: data buses are zero whenever they carry nothing live.
  always_comb begin
    InReadyxSO  = 1'b0;
    OutValidxSO = 1'b0;
    OutDataxDO  = '0;
    MapDataxDO  = '0;
    MapSelxSO   = 1'b0;
    MapValidxSO = 1'b0;
    BusyxSO     = 1'b1;
    ByteIdxxSO  = '0;
    unique case (fsm_q)
      StIdle: begin
        InReadyxSO = 1'b1;
        BusyxSO    = 1'b0;
      end
      StIssue: begin
        MapValidxSO = 1'b1;
        MapDataxDO  = mem_q[cnt_q];
        MapSelxSO   = sel_q;
        ByteIdxxSO  = cnt_q;
      end
      StDrain: ;
      StDone: begin
        OutValidxSO = 1'b1;
        for (int unsigned j = 0; j < COUNT; j++) OutDataxDO[ByteW*j +: ByteW] = mem_q[j];
      end
      default: ;
    endcase
  end

  // Only referenced by the optional clear path.
  logic unused_out_hs;
  assign unused_out_hs = out_hs;

endmodule

// File: tb/tb_msk_linmap_seq.sv
// Testbench for msk_linmap_seq: random and directed jobs, a byte mapper model
// with configurable latency, and a queue-based scoreboard checked by a monitor.
// The model mapper inverts share 0 when select is 1 and share D-1 when select
// is 0, so a wrong select shows up in the data; non-live issues return junk.

module tb_msk_linmap_seq;

  localparam int unsigned D     = 2;
  localparam int unsigned COUNT = 16;
  parameter  int unsigned LAT   = 1;
  localparam int unsigned BW    = 8 * D;
  localparam int unsigned SW    = BW * COUNT;
  localparam int unsigned IW    = $clog2(COUNT);

  logic          ClkxCI;
  logic          RstxBI;
  logic          InValidxSI;
  logic          InReadyxSO;
  logic [SW-1:0] InDataxDI;
  logic          InSelxSI;
  logic          OutValidxSO;
  logic          OutReadyxSI;
  logic [SW-1:0] OutDataxDO;
  logic [BW-1:0] MapDataxDO;
  logic          MapSelxSO;
  logic          MapValidxSO;
  logic [BW-1:0] MapDataxDI;
  logic          BusyxSO;
  logic [IW-1:0] ByteIdxxSO;

  msk_linmap_seq #(
    .D     (D),
    .COUNT (COUNT),
    .LAT   (LAT)
  ) dut (
    .ClkxCI      (ClkxCI),
    .RstxBI      (RstxBI),
    .InValidxSI  (InValidxSI),
    .InReadyxSO  (InReadyxSO),
    .InDataxDI   (InDataxDI),
    .InSelxSI    (InSelxSI),
    .OutValidxSO (OutValidxSO),
    .OutReadyxSI (OutReadyxSI),
    .OutDataxDO  (OutDataxDO),
    .MapDataxDO  (MapDataxDO),
    .MapSelxSO   (MapSelxSO),
    .MapValidxSO (MapValidxSO),
    .MapDataxDI  (MapDataxDI),
    .BusyxSO     (BusyxSO),
    .ByteIdxxSO  (ByteIdxxSO)
  );

  initial ClkxCI = 1'b0;
  always #5 ClkxCI = ~ClkxCI;

  int cyc = 0;
  always @(posedge ClkxCI) cyc <= cyc + 1;

  // ---------------- reference functions ----------------
  function automatic logic [BW-1:0] share_mask(input logic sel);
    logic [BW-1:0] m;
    int unsigned sh;
    m  = '0;
    sh = sel ? 0 : D - 1;
    for (int b = 0; b < 8; b++) m[D*b + sh] = 1'b1;
    return m;
  endfunction

  function automatic logic [SW-1:0] ref_map(input logic [SW-1:0] din, input logic sel);
    logic [SW-1:0] r;
    for (int j = 0; j < COUNT; j++) r[BW*j +: BW] = din[BW*j +: BW] ^ share_mask(sel);
    return r;
  endfunction

  // plain holds share s at [8*s +: 8]; shbit puts bit b of share s at D*b+s.
  function automatic logic [BW-1:0] shbit(input logic [BW-1:0] plain);
    logic [BW-1:0] r;
    for (int s = 0; s < D; s++)
      for (int b = 0; b < 8; b++) r[D*b + s] = plain[8*s + b];
    return r;
  endfunction

  // Byte j: share 0 = 8'h0j, share 1 = 8'hj0.
  function automatic logic [SW-1:0] pattern();
    logic [SW-1:0] r;
    logic [BW-1:0] plain;
    for (int j = 0; j < COUNT; j++) begin
      plain       = '0;
      plain[7:0]  = 8'(j);
      plain[15:8] = 8'(j << 4);
      r[BW*j +: BW] = shbit(plain);
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    for (int w = 0; w < SW / 32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- mapper model ----------------
  logic [BW-1:0] map_now;
  always_comb map_now = MapValidxSO ? (MapDataxDO ^ share_mask(MapSelxSO)) : {D{8'hC3}};

  if (LAT == 0) begin : g_map0
    assign MapDataxDI = map_now;
  end else begin : g_map
    logic [BW-1:0] mp [LAT];
    always @(posedge ClkxCI) begin
      mp[0] <= map_now;
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign MapDataxDI = mp[LAT-1];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [SW-1:0] din;
    logic          sel;
    logic [SW-1:0] dout;
    int            acc;
  } job_t;

  job_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   end_req;
  bit   mon_done;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    job_t          cur;
    job_t          front;
    int            iss_idx = 0;
    bit            out_act = 0;
    bit            prev_hs = 0;
    int            since   = 0;
    logic [SW-1:0] memv;
    cur = '0;
    forever begin
      @(negedge ClkxCI);
      if (!RstxBI) begin
        chk("rst_in_ready", SW'(InReadyxSO), SW'(1));
        chk("rst_flags", SW'({OutValidxSO, MapValidxSO, MapSelxSO, BusyxSO}), '0);
        chk("rst_byte_idx", SW'(ByteIdxxSO), '0);
        chk("rst_map_data", SW'(MapDataxDO), '0);
        chk("rst_out_data", OutDataxDO, '0);
        exp_q.delete();
        iss_idx = 0;
        out_act = 0;
        prev_hs = 0;
        since   = 0;
      end else begin
        since++;
        if (prev_hs) begin
          chk("idle_after_hs", SW'({InReadyxSO, OutValidxSO}), SW'(2'b10));
          for (int j = 0; j < COUNT; j++) memv[BW*j +: BW] = dut.mem_q[j];
`ifdef MSKLIN_SEQ_CLEAR_EN
          chk("buf_cleared", memv, '0);
`else
          chk("buf_retained", memv, cur.dout);
`endif
          prev_hs = 0;
        end
        if (InValidxSI && InReadyxSO) since = 0;
        if (MapValidxSO) begin
          chk("issue_has_job", SW'(exp_q.size() != 0), SW'(1));
          if (exp_q.size() != 0) begin
            front = exp_q[0];
            chk("byte_idx", SW'(ByteIdxxSO), SW'(iss_idx));
            chk("map_sel", SW'(MapSelxSO), SW'(front.sel));
            chk("map_data", SW'(MapDataxDO), SW'(front.din[BW*iss_idx +: BW]));
            chk("busy_issue", SW'(BusyxSO), SW'(1));
          end
          iss_idx++;
        end else begin
          chk("map_idle", SW'({ByteIdxxSO, MapDataxDO}), '0);
        end
        if (OutValidxSO) begin
          since = 0;
          if (!out_act) begin
            chk("output_has_job", SW'(exp_q.size() != 0), SW'(1));
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              chk("latency", SW'(cyc - cur.acc), SW'(COUNT + LAT + 1));
            end
            out_act = 1;
            iss_idx = 0;
          end
          chk("out_data", OutDataxDO, cur.dout);
          chk("in_ready_done", SW'({InReadyxSO, BusyxSO}), SW'(2'b01));
          if (OutReadyxSI) begin
            out_act = 0;
            prev_hs = 1;
          end
        end else begin
          chk("out_idle", OutDataxDO, '0);
        end
        if (since > 200) begin
          chk("watchdog_cycles", SW'(since), SW'(200));
          since = 0;
        end
        if (end_req && !mon_done) begin
          chk("pending_at_end", SW'({exp_q.size() != 0, out_act}), '0);
          mon_done = 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic start_job(input logic [SW-1:0] din, input logic sel, input logic rdy);
    int n = 0;
    @(posedge ClkxCI); #1;
    InValidxSI  = 1'b1;
    InDataxDI   = din;
    InSelxSI    = sel;
    OutReadyxSI = rdy;
    do begin
      @(negedge ClkxCI);
      n++;
    end while (!InReadyxSO && n < 100);
    if (InReadyxSO) exp_q.push_back('{din: din, sel: sel, dout: ref_map(din, sel), acc: cyc});
    @(posedge ClkxCI); #1;
    InValidxSI = 1'b0;
    InDataxDI  = rand_state();
    InSelxSI   = ~sel;
  endtask

  task automatic run_job(input logic [SW-1:0] din, input logic sel, input int stall,
                         input bit pulse);
    int n = 0;
    start_job(din, sel, stall == 0);
    while (!OutValidxSO && n < 200) begin
      @(negedge ClkxCI);
      n++;
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge ClkxCI); #1;
      if (pulse && k == 1) begin
        InValidxSI = 1'b1;
        InDataxDI  = rand_state();
        InSelxSI   = 1'($urandom);
      end else begin
        InValidxSI = 1'b0;
      end
    end
    @(posedge ClkxCI); #1;
    InValidxSI  = 1'b0;
    OutReadyxSI = 1'b1;
    @(posedge ClkxCI); #1;
    OutReadyxSI = 1'b0;
  endtask

  task automatic run_reset_job(input logic [SW-1:0] din, input logic sel);
    int n = 0;
    start_job(din, sel, 1'b1);
    while (!(MapValidxSO && ByteIdxxSO == IW'(7)) && n < 100) begin
      @(negedge ClkxCI);
      n++;
    end
    #2 RstxBI = 1'b0;
    repeat (2) @(negedge ClkxCI);
    @(posedge ClkxCI); #1;
    RstxBI      = 1'b1;
    OutReadyxSI = 1'b0;
  endtask

  initial begin
    int n;
    RstxBI      = 1'b1;
    InValidxSI  = 1'b0;
    InDataxDI   = '0;
    InSelxSI    = 1'b0;
    OutReadyxSI = 1'b0;
    end_req     = 1'b0;
    mon_done    = 1'b0;
    fork
      monitor();
    join_none
    #1 RstxBI = 1'b0;
    repeat (3) @(negedge ClkxCI);
    @(posedge ClkxCI); #1;
    RstxBI = 1'b1;

    run_job(pattern(), 1'b1, 0, 1'b0);
    run_job(rand_state(), 1'b1, 5, 1'b1);
    run_reset_job(rand_state(), 1'($urandom));
    run_job(pattern(), 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++)
      run_job(rand_state(), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);

    repeat (3) @(negedge ClkxCI);
    end_req = 1'b1;
    n = 0;
    while (!mon_done && n < 10) begin
      @(negedge ClkxCI);
      n++;
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msk_linmap_seq.md
Name: msk_linmap_seq

Overview:
- Time-multiplexed sequencer that applies a masked byte-wise linear map to a full shared AES state using a single shared byte-mapper instance.
- Accepts a bit-interleaved shared state (shbit encoding) through a valid/ready handshake and buffers it.
- Issues one shared byte per cycle to an external pipelined mapper, writes each result back in place, then presents the mapped state through a valid/ready handshake.
- Sits between the round datapath and the masked input/output linear-map hardware; it replaces COUNT parallel mapper copies with one.

Parameters:
- D, 2, number of shares (masking order + 1).
- COUNT, 16, number of bytes in the state.
- LAT, 1, fixed mapper latency in cycles from MapValidxSO to MapDataxDI; legal range 0..4.

Ports:
- ClkxCI  in  1  clock
- RstxBI  in  1  asynchronous active-low reset
- InValidxSI  in  1  input state valid
- InReadyxSO  out  1  block can accept a state
- InDataxDI  in  8*COUNT*D  shared state, shbit encoding; byte j occupies [8*D*j +: 8*D]
- InSelxSI  in  1  matrix select for this job; sampled at accept
- OutValidxSO  out  1  mapped state valid
- OutReadyxSI  in  1  consumer accepts the mapped state
- OutDataxDO  out  8*COUNT*D  mapped shared state, shbit encoding
- MapDataxDO  out  8*D  shared byte sent to the mapper
- MapSelxSO  out  1  matrix select to the mapper
- MapValidxSO  out  1  MapDataxDO is a live issue
- MapDataxDI  in  8*D  mapper result, LAT cycles after issue
- BusyxSO  out  1  high in ISSUE, DRAIN or DONE
- ByteIdxxSO  out  clog2(COUNT)  index of the byte issued this cycle (0 when not issuing)

Behaviour:
- Reset (async, RstxBI=0): FSM goes to IDLE. State buffer, counters, latched select and the capture valid pipe are all cleared.
  - Reset values: InReadyxSO=1, OutValidxSO=0, MapValidxSO=0, MapSelxSO=0, BusyxSO=0, ByteIdxxSO=0, MapDataxDO=0, OutDataxDO=0.
- Reset asserted mid-job: the job is discarded with no output. In-flight mapper results returning after reset release are ignored, because the cleared valid pipe marks them as not live.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: InReadyxSO=1. On InValidxSI & InReadyxSO, latch InDataxDI into the buffer and InSelxSI into the select register, clear the issue counter, then go to ISSUE.
  - ISSUE: issue byte i = issue counter each cycle. MapValidxSO=1, MapDataxDO = buffer byte i, MapSelxSO = latched select, ByteIdxxSO = i. The counter increments every cycle. At i=COUNT-1, go to DRAIN if LAT>0, otherwise go to DONE.
  - DRAIN: stay while any capture is still pending; go to DONE on the cycle the final capture is written.
- Capture:
  - A valid/index shift pipe of depth LAT tracks issues.
  - When the pipe tail is valid, MapDataxDI is written into buffer byte = tail index at that clock edge.
  - With LAT=0, capture happens on the same edge as the issue.
  - No stalls: the mapper is assumed always ready.
- DONE:
  - OutValidxSO=1 and OutDataxDO = buffer.
  - Both stay stable until OutReadyxSI=1; on that handshake edge, go to IDLE.
  - There is no same-cycle restart: InReadyxSO is 0 in DONE and rises in the following cycle.
- Latency: accept edge at cycle c gives OutValidxSO high in cycle c+COUNT+LAT+1. Job period is COUNT+LAT+2 cycles minimum.
- Leakage hygiene:
  - MapDataxDO is forced to 0 whenever MapValidxSO=0.
  - OutDataxDO is forced to 0 outside DONE.
  - Shares of one byte are never combined; the block only moves 8*D-bit slices.
- InValidxSI while not in IDLE is ignored, and InDataxDI is not sampled.
- The issue counter is clog2(COUNT) bits. The terminal compare is at COUNT-1, with no reliance on natural wrap, so non-power-of-2 COUNT is supported.

Optional Feature:
- Macro: MSKLIN_SEQ_CLEAR_EN.
- Defined: on the DONE output handshake edge, the state buffer and select register are cleared to 0, so no share residue remains in IDLE. This costs no extra cycle.
- Not defined: the buffer keeps the last mapped state until the next accept overwrites it. Functional outputs are identical in both builds, because OutDataxDO is gated in either case.

Test Plan:
- D=2, COUNT=16, LAT=1. Bench mapper returns its input XOR 8'hFF on share 0 only. Accept state with byte j = {8'h0j,8'hj0} interleaved -> OutValidxSO rises exactly 18 cycles after the accept edge; every byte has share 0 inverted and share 1 unchanged.
- OutReadyxSI held 0 for 5 cycles in DONE -> OutDataxDO stable and InReadyxSO=0 throughout; a new InValidxSI pulse in that window is ignored; on release, IDLE follows one cycle later.
- InSelxSI=1 at accept, then toggled to 0 during ISSUE -> MapSelxSO stays 1 for all 16 issues; ByteIdxxSO steps 0..15 on consecutive cycles.
- LAT=0 and LAT=4 builds -> OutValidxSO rises 17 and 21 cycles after accept respectively; data is correct in both.
- RstxBI pulsed low at issue 7, then a fresh job is run -> outputs are at reset values immediately; the fresh job completes correctly with no corruption from stale returns.
- With MSKLIN_SEQ_CLEAR_EN defined -> after the output handshake, the internal buffer reads all zeros; without it, the buffer still holds the mapped state.
